// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM for the multi-cycle RV32I subset core: steps the shared
// datapath through fetch/decode/execute/memory/writeback and picks the ALU op.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       regWrite,
  output logic [1:0] immSrc,
  output logic [2:0] aluCtr,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state;
  state_t nextState;
  state_t curState;

  function automatic logic functOk(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // funct7b5 only selects sub for register-register ops; there is no subi.
  function automatic logic [2:0] functDecode(input logic [2:0] f3, input logic f7b5,
                                             input logic isR);
    case (f3)
      3'b000:  return (isR && f7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= state_t'(RESET_STATE);
    else     state <= nextState;
  end

  always_comb begin
    immSrc = 2'b00;
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  always_comb begin
    // While in reset the outputs present the reset state, with writes suppressed below.
    curState  = rst ? state_t'(RESET_STATE) : state;
    nextState = FETCH;
    pcWrite   = 1'b0;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    regWrite  = 1'b0;
    aluCtr    = 3'b000;
    illegal   = 1'b0;
    case (curState)
      FETCH: begin
        irWrite   = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        pcWrite   = 1'b1;
        nextState = DECODE;
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_R:         nextState = functOk(funct3) ? EXECR : TRAP;
          OP_I:         nextState = functOk(funct3) ? EXECI : TRAP;
          OP_BEQ:       nextState = BEQ;
          OP_JAL:       nextState = JAL;
          default:      nextState = TRAP;
        endcase
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        if (op == OP_LW)      nextState = MEMREAD;
        else if (op == OP_SW) nextState = MEMWRITE;
        else                  nextState = TRAP;
      end
      MEMREAD: begin
        adrSrc    = 1'b1;
        nextState = MEMWB;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
      end
      MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
      end
      EXECR: begin
        aluSrcA   = 2'b10;
        aluCtr    = functDecode(funct3, funct7b5, 1'b1);
        nextState = ALUWB;
      end
      EXECI: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        aluCtr    = functDecode(funct3, funct7b5, 1'b0);
        nextState = ALUWB;
      end
      ALUWB: regWrite = 1'b1;
      BEQ: begin
        aluSrcA = 2'b10;
        aluCtr  = 3'b001;
        pcWrite = zero;
      end
      JAL: begin
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        pcWrite   = 1'b1;
        nextState = ALUWB;
      end
      TRAP: begin
        illegal   = 1'b1;
        nextState = TRAP;
      end
      default: nextState = FETCH;
    endcase
    if (rst) begin
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      regWrite = 1'b0;
      memWrite = 1'b0;
    end
  end

  assign state_o = curState;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus pushes the hand-derived
// output vector for each cycle; a monitor pops and compares on the falling edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0] aluCtr;
  logic [3:0] state_o;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .regWrite(regWrite),
    .immSrc(immSrc), .aluCtr(aluCtr), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [20:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  bit   done = 0;

  // Hand-written per-state table: {adrSrc, memWrite, irWrite, resultSrc, A, B, regWrite, illegal}
  function automatic logic [10:0] stateTbl(input logic [3:0] st);
    case (st)
      4'd0:    return 11'b0_0_1_10_00_10_0_0;
      4'd1:    return 11'b0_0_0_00_01_01_0_0;
      4'd2:    return 11'b0_0_0_00_10_01_0_0;
      4'd3:    return 11'b1_0_0_00_00_00_0_0;
      4'd4:    return 11'b0_0_0_01_00_00_1_0;
      4'd5:    return 11'b1_1_0_00_00_00_0_0;
      4'd6:    return 11'b0_0_0_00_10_00_0_0;
      4'd7:    return 11'b0_0_0_00_10_01_0_0;
      4'd8:    return 11'b0_0_0_00_00_00_1_0;
      4'd9:    return 11'b0_0_0_00_10_00_0_0;
      4'd10:   return 11'b0_0_0_00_01_10_0_0;
      4'd11:   return 11'b0_0_0_00_00_00_0_1;
      default: return 11'b0;
    endcase
  endfunction

  // Push the expectation for the current cycle, then move past the next rising edge.
  task automatic step(input string name, input logic [3:0] st, input logic pcw,
                      input logic [1:0] imm, input logic [2:0] alu);
    logic [10:0] t;
    exp_t e;
    t = stateTbl(st);
    e.name = name;
    e.v = {st, pcw, t[10:1], imm, alu, t[0]};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Cycle with rst high: FETCH-like outputs with every write enable low.
  task automatic stepRst(input string name, input logic [1:0] imm);
    exp_t e;
    e.name = name;
    e.v = {4'd0, 1'b0, 10'b0_0_0_10_00_10_0, imm, 3'b000, 1'b0};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic setInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
  endtask

  always @(negedge clk) begin
    logic [20:0] act;
    exp_t e;
    act = {state_o, pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
           regWrite, immSrc, aluCtr, illegal};
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (act === e.v) passed++;
      else $display("FAIL %s: got %b required %b", e.name, act, e.v);
    end
    total++;
    if ((regWrite && memWrite) || (regWrite && pcWrite))
      $display("FAIL exclusive_enables: regWrite=%b memWrite=%b pcWrite=%b",
               regWrite, memWrite, pcWrite);
    else passed++;
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset held for two cycles
    stepRst("rst0", 2'b00);
    stepRst("rst1", 2'b00);
    rst = 1'b0;

    // R-type sub
    setInstr(7'b0110011, 3'b000, 1'b1);
    step("sub_fetch", 4'd0, 1'b1, 2'b00, 3'b000);
    step("sub_decode", 4'd1, 1'b0, 2'b00, 3'b000);
    step("sub_execr", 4'd6, 1'b0, 2'b00, 3'b001);
    step("sub_aluwb", 4'd8, 1'b0, 2'b00, 3'b000);

    // R-type and
    setInstr(7'b0110011, 3'b111, 1'b0);
    step("and_fetch", 4'd0, 1'b1, 2'b00, 3'b000);
    step("and_decode", 4'd1, 1'b0, 2'b00, 3'b000);
    step("and_execr", 4'd6, 1'b0, 2'b00, 3'b010);
    step("and_aluwb", 4'd8, 1'b0, 2'b00, 3'b000);

    // lw
    setInstr(7'b0000011, 3'b010, 1'b0);
    step("lw_fetch", 4'd0, 1'b1, 2'b00, 3'b000);
    step("lw_decode", 4'd1, 1'b0, 2'b00, 3'b000);
    step("lw_memadr", 4'd2, 1'b0, 2'b00, 3'b000);
    step("lw_memread", 4'd3, 1'b0, 2'b00, 3'b000);
    step("lw_memwb", 4'd4, 1'b0, 2'b00, 3'b000);

    // sw
    setInstr(7'b0100011, 3'b010, 1'b0);
    step("sw_fetch", 4'd0, 1'b1, 2'b01, 3'b000);
    step("sw_decode", 4'd1, 1'b0, 2'b01, 3'b000);
    step("sw_memadr", 4'd2, 1'b0, 2'b01, 3'b000);
    step("sw_memwrite", 4'd5, 1'b0, 2'b01, 3'b000);

    // beq taken, then not taken
    setInstr(7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    step("beqT_fetch", 4'd0, 1'b1, 2'b10, 3'b000);
    step("beqT_decode", 4'd1, 1'b0, 2'b10, 3'b000);
    step("beqT_beq", 4'd9, 1'b1, 2'b10, 3'b001);
    zero = 1'b0;
    step("beqN_fetch", 4'd0, 1'b1, 2'b10, 3'b000);
    step("beqN_decode", 4'd1, 1'b0, 2'b10, 3'b000);
    step("beqN_beq", 4'd9, 1'b0, 2'b10, 3'b001);

    // jal
    setInstr(7'b1101111, 3'b000, 1'b0);
    step("jal_fetch", 4'd0, 1'b1, 2'b11, 3'b000);
    step("jal_decode", 4'd1, 1'b0, 2'b11, 3'b000);
    step("jal_jal", 4'd10, 1'b1, 2'b11, 3'b000);
    step("jal_aluwb", 4'd8, 1'b0, 2'b11, 3'b000);

    // addi with funct7b5=1 must still add
    setInstr(7'b0010011, 3'b000, 1'b1);
    step("addi_fetch", 4'd0, 1'b1, 2'b00, 3'b000);
    step("addi_decode", 4'd1, 1'b0, 2'b00, 3'b000);
    step("addi_execi", 4'd7, 1'b0, 2'b00, 3'b000);
    step("addi_aluwb", 4'd8, 1'b0, 2'b00, 3'b000);

    // slti
    setInstr(7'b0010011, 3'b010, 1'b1);
    step("slti_fetch", 4'd0, 1'b1, 2'b00, 3'b000);
    step("slti_decode", 4'd1, 1'b0, 2'b00, 3'b000);
    step("slti_execi", 4'd7, 1'b0, 2'b00, 3'b101);
    step("slti_aluwb", 4'd8, 1'b0, 2'b00, 3'b000);

    // Unknown opcode traps and stays trapped until reset
    setInstr(7'b1111111, 3'b000, 1'b0);
    step("bad_fetch", 4'd0, 1'b1, 2'b00, 3'b000);
    step("bad_decode", 4'd1, 1'b0, 2'b00, 3'b000);
    for (int i = 0; i < 10; i++) step($sformatf("trap_%0d", i), 4'd11, 1'b0, 2'b00, 3'b000);
    rst = 1'b1;
    stepRst("trap_rst", 2'b00);
    rst = 1'b0;

    // R-type with an unsupported funct3 traps
    setInstr(7'b0110011, 3'b001, 1'b0);
    step("r001_fetch", 4'd0, 1'b1, 2'b00, 3'b000);
    step("r001_decode", 4'd1, 1'b0, 2'b00, 3'b000);
    step("r001_trap", 4'd11, 1'b0, 2'b00, 3'b000);
    rst = 1'b1;
    stepRst("r001_rst", 2'b00);
    rst = 1'b0;

    // Reset arriving in MEMREAD aborts the lw with no register write
    setInstr(7'b0000011, 3'b010, 1'b0);
    step("lwab_fetch", 4'd0, 1'b1, 2'b00, 3'b000);
    step("lwab_decode", 4'd1, 1'b0, 2'b00, 3'b000);
    step("lwab_memadr", 4'd2, 1'b0, 2'b00, 3'b000);
    rst = 1'b1;
    stepRst("lwab_rst", 2'b00);
    rst = 1'b0;
    setInstr(7'b0110011, 3'b110, 1'b0);
    step("or_fetch", 4'd0, 1'b1, 2'b00, 3'b000);
    step("or_decode", 4'd1, 1'b0, 2'b00, 3'b000);
    step("or_execr", 4'd6, 1'b0, 2'b00, 3'b011);
    step("or_aluwb", 4'd8, 1'b0, 2'b00, 3'b000);
    step("or_next", 4'd0, 1'b1, 2'b00, 3'b000);

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) $display("FAIL scoreboard_drain: %0d left, required 0", q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
